// File: rtl/blk_51c509_pkg.sv
// ----------------------------------------------------------------------------
// blk_51c509_pkg
//   Shared constants and state encoding for the write-burst splitter.
//   LINE_BYTES / PAGE_LINES describe the line and 4KB-page geometry used to
//   cut AFU write bursts into PCIe-legal packets.
// ----------------------------------------------------------------------------
package blk_51c509_pkg;

    localparam int unsigned LINE_BYTES    = 64;
    localparam int unsigned LINE_ADDR_LSB = 6;    // log2(LINE_BYTES)
    localparam int unsigned PAGE_LINES    = 64;   // lines per 4KB page
    localparam int unsigned PAGE_ADDR_LSB = 12;   // log2(4096)

    typedef logic [0:0] t_wr_split_state;
    localparam t_wr_split_state IDLE  = 1'b0;
    localparam t_wr_split_state BURST = 1'b1;

endpackage

// File: rtl/blk_51c509_pkt_len.sv
// ----------------------------------------------------------------------------
// blk_51c509_pkt_len
//   Combinational packet sizer: lines in the next packet given the line index
//   within the current 4KB page and the lines remaining in the burst.
//   pkt = min(remaining, MAX_PAYLOAD_LINES, PAGE_LINES - line_idx)
// Ports:
//   line_idx   in   cur_addr[11:6], line position inside the page
//   remaining  in   lines left in the burst
//   pkt_lines  out  lines in the packet starting at this line
// ----------------------------------------------------------------------------
module blk_51c509_pkt_len
    import blk_51c509_pkg::*;
#(
    parameter int unsigned BURST_CNT_WIDTH   = 8,
    parameter int unsigned MAX_PAYLOAD_LINES = 2
) (
    input  logic [PAGE_ADDR_LSB-LINE_ADDR_LSB-1:0] line_idx,
    input  logic [BURST_CNT_WIDTH-1:0]             remaining,
    output logic [BURST_CNT_WIDTH-1:0]             pkt_lines
);

    // One extra bit so lines_to_page == 64 survives with narrow count widths.
    localparam int unsigned W = BURST_CNT_WIDTH + 1;

    logic [W-1:0] lines_to_page;
    logic [W-1:0] lim;

    always_comb begin
        lines_to_page = W'(PAGE_LINES) - W'(line_idx);
        lim = W'(remaining);
        if (W'(MAX_PAYLOAD_LINES) < lim) lim = W'(MAX_PAYLOAD_LINES);
        if (lines_to_page < lim)         lim = lines_to_page;
        // Result never exceeds remaining, so it fits the count width.
        pkt_lines = BURST_CNT_WIDTH'(lim);
    end

endmodule

// File: rtl/blk_51c509.sv
// ----------------------------------------------------------------------------
// blk_51c509
//   Write-burst splitter feeding the write-TLP generator. Accepts AFU write
//   bursts (header on the first beat, one line per beat) and fences, and
//   re-emits them as packets that never exceed MAX_PAYLOAD_LINES and never
//   cross a 4KB page. One output register stage, 1 cycle latency.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   in_valid/in_ready  input handshake; in_ready = !out_valid || out_ready
//   in_sop/in_eop      first / last beat of an AFU request
//   in_is_fence        fence request (single beat)
//   in_addr/len/tag    burst header, valid with in_sop
//   in_data            write data line
//   out_valid/ready    output handshake
//   out_sop/out_eop    packet boundaries; out_burst_eop marks request end
//   out_is_fence       fence packet
//   out_addr/line_count  packet header, valid with out_sop
//   out_tag/out_data   AFU tag and payload line
//   error              sticky protocol error
// ----------------------------------------------------------------------------
module blk_51c509
    import blk_51c509_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH        = 64,
    parameter int unsigned DATA_WIDTH        = 512,
    parameter int unsigned TAG_WIDTH         = 10,
    parameter int unsigned BURST_CNT_WIDTH   = 8,
    parameter int unsigned MAX_PAYLOAD_LINES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sop,
    input  logic                       in_eop,
    input  logic                       in_is_fence,
    input  logic [ADDR_WIDTH-1:0]      in_addr,
    input  logic [BURST_CNT_WIDTH-1:0] in_len,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic                       out_burst_eop,
    output logic                       out_is_fence,
    output logic [ADDR_WIDTH-1:0]      out_addr,
    output logic [BURST_CNT_WIDTH-1:0] out_line_count,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       error
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

    t_wr_split_state              state_q, state_d;
    logic [ADDR_WIDTH-1:0]        cur_addr_q, cur_addr_d;
    logic [BURST_CNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [BURST_CNT_WIDTH-1:0]   pkt_left_q, pkt_left_d;
    logic [TAG_WIDTH-1:0]         tag_q, tag_d;
    logic                         error_q, error_d;

    logic                         out_valid_q, out_valid_d;
    logic                         out_sop_q, out_sop_d;
    logic                         out_eop_q, out_eop_d;
    logic                         out_burst_eop_q, out_burst_eop_d;
    logic                         out_is_fence_q, out_is_fence_d;
    logic [ADDR_WIDTH-1:0]        out_addr_q, out_addr_d;
    logic [BURST_CNT_WIDTH-1:0]   out_line_count_q, out_line_count_d;
    logic [TAG_WIDTH-1:0]         out_tag_q, out_tag_d;
    logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;

    // Per-beat working values: either the fresh header (IDLE) or the
    // registered burst context (BURST).
    logic                         accept;
    logic                         do_beat;
    logic [ADDR_WIDTH-1:0]        beat_addr;
    logic [BURST_CNT_WIDTH-1:0]   beat_rem;
    logic [BURST_CNT_WIDTH-1:0]   beat_left;
    logic [TAG_WIDTH-1:0]         beat_tag;
    logic [BURST_CNT_WIDTH-1:0]   pkt_lines;
    logic [BURST_CNT_WIDTH-1:0]   left_n;
    logic [BURST_CNT_WIDTH-1:0]   rem_n;
    logic                         first;

    blk_51c509_pkt_len #(
        .BURST_CNT_WIDTH   (BURST_CNT_WIDTH),
        .MAX_PAYLOAD_LINES (MAX_PAYLOAD_LINES)
    ) u_pkt_len (
        .line_idx  (beat_addr[PAGE_ADDR_LSB-1:LINE_ADDR_LSB]),
        .remaining (beat_rem),
        .pkt_lines (pkt_lines)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d          = state_q;
        cur_addr_d       = cur_addr_q;
        remaining_d      = remaining_q;
        pkt_left_d       = pkt_left_q;
        tag_d            = tag_q;
        error_d          = error_q;
        out_valid_d      = out_valid_q;
        out_sop_d        = out_sop_q;
        out_eop_d        = out_eop_q;
        out_burst_eop_d  = out_burst_eop_q;
        out_is_fence_d   = out_is_fence_q;
        out_addr_d       = out_addr_q;
        out_line_count_d = out_line_count_q;
        out_tag_d        = out_tag_q;
        out_data_d       = out_data_q;

        do_beat   = 1'b0;
        beat_addr = cur_addr_q;
        beat_rem  = remaining_q;
        beat_left = pkt_left_q;
        beat_tag  = tag_q;
        first     = 1'b0;
        left_n    = '0;
        rem_n     = '0;

        // Output slot frees up whenever the downstream can take it.
        if (in_ready) out_valid_d = 1'b0;

        if (accept) begin
            if (state_q == IDLE) begin
                if (in_sop && in_is_fence) begin
                    out_valid_d      = 1'b1;
                    out_sop_d        = 1'b1;
                    out_eop_d        = 1'b1;
                    out_burst_eop_d  = 1'b1;
                    out_is_fence_d   = 1'b1;
                    out_addr_d       = '0;
                    out_line_count_d = BURST_CNT_WIDTH'(1);
                    out_tag_d        = in_tag;
                    out_data_d       = '0;
                end else if (in_sop) begin
                    if ((in_addr & LINE_MASK) != '0) error_d = 1'b1;
                    if (in_len == '0)                error_d = 1'b1;
                    do_beat   = 1'b1;
                    beat_addr = in_addr & ~LINE_MASK;
                    beat_rem  = (in_len == '0) ? BURST_CNT_WIDTH'(1) : in_len;
                    beat_left = '0;
                    beat_tag  = in_tag;
                end
                // Non-sop beats in IDLE belong to no request and are dropped.
            end else begin
                if (in_sop) error_d = 1'b1;
                do_beat = 1'b1;
            end
        end

        if (do_beat) begin
            first  = (beat_left == '0);
            left_n = (first ? pkt_lines : beat_left) - BURST_CNT_WIDTH'(1);
            rem_n  = beat_rem - BURST_CNT_WIDTH'(1);
            // The line count is authoritative over the AFU's eop marking.
            if (in_eop != (beat_rem == BURST_CNT_WIDTH'(1))) error_d = 1'b1;

            out_valid_d     = 1'b1;
            out_sop_d       = first;
            out_eop_d       = (left_n == '0);
            out_burst_eop_d = (rem_n == '0);
            out_is_fence_d  = 1'b0;
            out_addr_d      = beat_addr;
            if (first) out_line_count_d = pkt_lines;
            out_tag_d       = beat_tag;
            out_data_d      = in_data;

            cur_addr_d  = beat_addr + ADDR_WIDTH'(LINE_BYTES);
            remaining_d = rem_n;
            pkt_left_d  = left_n;
            tag_d       = beat_tag;
            state_d     = (rem_n == '0) ? IDLE : BURST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            cur_addr_q       <= '0;
            remaining_q      <= '0;
            pkt_left_q       <= '0;
            tag_q            <= '0;
            error_q          <= 1'b0;
            out_valid_q      <= 1'b0;
            out_sop_q        <= 1'b0;
            out_eop_q        <= 1'b0;
            out_burst_eop_q  <= 1'b0;
            out_is_fence_q   <= 1'b0;
            out_addr_q       <= '0;
            out_line_count_q <= '0;
            out_tag_q        <= '0;
            out_data_q       <= '0;
        end else begin
            state_q          <= state_d;
            cur_addr_q       <= cur_addr_d;
            remaining_q      <= remaining_d;
            pkt_left_q       <= pkt_left_d;
            tag_q            <= tag_d;
            error_q          <= error_d;
            out_valid_q      <= out_valid_d;
            out_sop_q        <= out_sop_d;
            out_eop_q        <= out_eop_d;
            out_burst_eop_q  <= out_burst_eop_d;
            out_is_fence_q   <= out_is_fence_d;
            out_addr_q       <= out_addr_d;
            out_line_count_q <= out_line_count_d;
            out_tag_q        <= out_tag_d;
            out_data_q       <= out_data_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_sop        = out_sop_q;
    assign out_eop        = out_eop_q;
    assign out_burst_eop  = out_burst_eop_q;
    assign out_is_fence   = out_is_fence_q;
    assign out_addr       = out_addr_q;
    assign out_line_count = out_line_count_q;
    assign out_tag        = out_tag_q;
    assign out_data       = out_data_q;
    assign error          = error_q;

endmodule

// File: tb/tb_blk_51c509.sv
// ----------------------------------------------------------------------------
// tb_blk_51c509
//   Scoreboard bench for the write-burst splitter: the stimulus side pushes
//   the expected output beats, a negedge monitor pops and compares each beat
//   the DUT hands over.
// ----------------------------------------------------------------------------
module tb_blk_51c509;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sop = 1'b0;
    logic         in_eop = 1'b0;
    logic         in_is_fence = 1'b0;
    logic [63:0]  in_addr = '0;
    logic [7:0]   in_len = '0;
    logic [9:0]   in_tag = '0;
    logic [511:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_sop, out_eop, out_burst_eop, out_is_fence;
    logic [63:0]  out_addr;
    logic [7:0]   out_line_count;
    logic [9:0]   out_tag;
    logic [511:0] out_data;
    logic         error;

    blk_51c509 #(
        .ADDR_WIDTH        (64),
        .DATA_WIDTH        (512),
        .TAG_WIDTH         (10),
        .BURST_CNT_WIDTH   (8),
        .MAX_PAYLOAD_LINES (2)
    ) dut (
        .clk            (clk),
        .reset          (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_is_fence    (in_is_fence),
        .in_addr        (in_addr),
        .in_len         (in_len),
        .in_tag         (in_tag),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_burst_eop  (out_burst_eop),
        .out_is_fence   (out_is_fence),
        .out_addr       (out_addr),
        .out_line_count (out_line_count),
        .out_tag        (out_tag),
        .out_data       (out_data),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sop, eop, beop, fence;
        logic [63:0]  addr;
        logic [7:0]   lc;
        logic [9:0]   tag;
        logic [511:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   sop_seen = 0;
    int   stall_cnt = 0;
    bit   rand_ready = 1'b0;

    function automatic logic [511:0] dat(input int unsigned n);
        return {16{n ^ 32'hA5A5_0000}};
    endfunction

    task automatic push_exp(input logic sop, eop, beop, fence, input logic [63:0] addr,
                            input logic [7:0] lc, input logic [9:0] tag, input logic [511:0] d);
        exp_t e;
        e.sop = sop; e.eop = eop; e.beop = beop; e.fence = fence;
        e.addr = addr; e.lc = lc; e.tag = tag; e.data = d;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Drives one beat, starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic sop, eop, fence, input logic [63:0] addr,
                        input logic [7:0] len, input logic [9:0] tag, input logic [511:0] d);
        int unsigned waits = 0;
        in_valid = 1'b1; in_sop = sop; in_eop = eop; in_is_fence = fence;
        in_addr = addr; in_len = len; in_tag = tag; in_data = d;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            stall_cnt++;
            waits++;
            if (waits > 500) begin
                n_vec++; n_bad++;
                $display("FAIL in_ready_timeout: waited %0d cycles, required <= 500", waits);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_is_fence = 1'b0;
    endtask

    task automatic write_burst(input logic [63:0] addr, input int unsigned len,
                               input logic [9:0] tag, input int unsigned seq);
        for (int unsigned i = 0; i < len; i++)
            send(i == 0, i == len - 1, 1'b0, addr, 8'(len), tag, dat(seq + i));
    endtask

    task automatic drain();
        int unsigned cyc = 0;
        while (sb.size() != 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    // Output-ready driver: held at 1 unless the random phase is active.
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare every beat the DUT hands over against the scoreboard.
    initial begin
        exp_t e;
        bit ok;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_vec++;
                if (out_sop) sop_seen++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_beat: got sop=%b addr=%0h tag=%0h, required no beat",
                             out_sop, out_addr, out_tag);
                end else begin
                    e = sb.pop_front();
                    ok = (out_sop === e.sop) && (out_eop === e.eop) &&
                         (out_burst_eop === e.beop) && (out_is_fence === e.fence) &&
                         (out_tag === e.tag);
                    if (e.sop)    ok = ok && (out_addr === e.addr) && (out_line_count === e.lc);
                    if (!e.fence) ok = ok && (out_data === e.data);
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL out_beat: got sop=%b eop=%b beop=%b fence=%b addr=%0h lc=%0d tag=%0h d=%0h, required sop=%b eop=%b beop=%b fence=%b addr=%0h lc=%0d tag=%0h d=%0h",
                                 out_sop, out_eop, out_burst_eop, out_is_fence, out_addr,
                                 out_line_count, out_tag, out_data[31:0],
                                 e.sop, e.eop, e.beop, e.fence, e.addr, e.lc, e.tag, e.data[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        int sop_base;
        logic [63:0] a;
        int unsigned rem, ltp, pkt, seq;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_error",     {63'd0, error},     64'd0);
        chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: 0x1000 len 4 -> (0x1000,2),(0x1080,2), full throughput
        push_exp(1, 0, 0, 0, 64'h1000, 2, 10'h011, dat(100));
        push_exp(0, 1, 0, 0, 64'h1040, 0, 10'h011, dat(101));
        push_exp(1, 0, 0, 0, 64'h1080, 2, 10'h011, dat(102));
        push_exp(0, 1, 1, 0, 64'h10C0, 0, 10'h011, dat(103));
        stall_cnt = 0;
        write_burst(64'h1000, 4, 10'h011, 100);
        chk("t1_stall_cycles", 64'(stall_cnt), 64'd0);
        drain();

        // 2: 0x1FC0 len 3 -> (0x1FC0,1),(0x2000,2); page boundary respected
        push_exp(1, 1, 0, 0, 64'h1FC0, 1, 10'h022, dat(200));
        push_exp(1, 0, 0, 0, 64'h2000, 2, 10'h022, dat(201));
        push_exp(0, 1, 1, 0, 64'h2040, 0, 10'h022, dat(202));
        write_burst(64'h1FC0, 3, 10'h022, 200);
        drain();

        // 3: fence between two writes, order preserved
        push_exp(1, 1, 1, 0, 64'h2000, 1, 10'h001, dat(300));
        push_exp(1, 1, 1, 1, 64'h0,    1, 10'h02A, '0);
        push_exp(1, 1, 1, 0, 64'h3040, 1, 10'h003, dat(301));
        write_burst(64'h2000, 1, 10'h001, 300);
        send(1'b1, 1'b1, 1'b1, 64'hDEAD_0000, 8'd1, 10'h02A, dat(999));
        write_burst(64'h3040, 1, 10'h003, 301);
        drain();

        // 4: len 255 at 0x5000 under random backpressure -> 128 packets
        a = 64'h5000; rem = 255; seq = 1000;
        while (rem > 0) begin
            ltp = 64 - int'(a[11:6]);
            pkt = (rem < 2) ? rem : 2;
            if (ltp < pkt) pkt = ltp;
            for (int unsigned j = 0; j < pkt; j++) begin
                push_exp(j == 0, j == pkt - 1, rem == 1, 0, a, 8'(pkt), 10'h155, dat(seq));
                a = a + 64; rem--; seq++;
            end
        end
        sop_base = sop_seen;
        rand_ready = 1'b1;
        write_burst(64'h5000, 255, 10'h155, 1000);
        drain();
        rand_ready = 1'b0;
        @(posedge clk); #1;
        chk("t4_packet_count", 64'(sop_seen - sop_base), 64'd128);
        chk("error_clean_traffic", {63'd0, error}, 64'd0);

        // 5: misaligned sop, sticky error, zero length
        push_exp(1, 1, 1, 0, 64'h1000, 1, 10'h005, dat(500));
        write_burst(64'h1010, 1, 10'h005, 500);
        drain();
        chk("t5_error_misaligned", {63'd0, error}, 64'd1);
        push_exp(1, 1, 1, 0, 64'h4000, 1, 10'h006, dat(501));
        write_burst(64'h4000, 1, 10'h006, 501);
        drain();
        chk("t5_error_sticky", {63'd0, error}, 64'd1);
        push_exp(1, 1, 1, 0, 64'h7000, 1, 10'h007, dat(502));
        send(1'b1, 1'b1, 1'b0, 64'h7000, 8'd0, 10'h007, dat(502));
        drain();
        chk("t5_error_len0", {63'd0, error}, 64'd1);

        // 6: reset during beat 2 of a 4-beat burst
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_exp(1, 0, 0, 0, 64'h6000, 2, 10'h00A, dat(600));
        send(1'b1, 1'b0, 1'b0, 64'h6004, 8'd4, 10'h00A, dat(600));
        send(1'b0, 1'b0, 1'b0, 64'h6004, 8'd4, 10'h00A, dat(601));
        chk("t6_error_before_reset", {63'd0, error}, 64'd1);
        chk("t6_valid_before_reset", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_reset_error",     {63'd0, error},     64'd0);
        chk("t6_beat1_consumed",  64'(sb.size()),     64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_exp(1, 0, 0, 0, 64'h3000, 2, 10'h00B, dat(610));
        push_exp(0, 1, 1, 0, 64'h3040, 0, 10'h00B, dat(611));
        write_burst(64'h3000, 2, 10'h00B, 610);
        drain();
        chk("t6_error_after", {63'd0, error}, 64'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
